// File: rtl/serial_chunk_adder_if.sv
// Operand/result handshake bundle for serial_chunk_adder.
// Optional sub/ovf signals exist only when SERIAL_ADD_SUB_EN is defined.
interface serial_chunk_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
  logic             ovf;
`endif

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per clock, LSB slice first, with a
// registered carry between slices and valid/ready on both sides.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds sub input and ovf output).
module serial_chunk_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_chunk_adder_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Reject illegal slicing at elaboration.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("serial_chunk_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CHUNK:0]   slice_sum;
  logic             msb_cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             ovf_q, ovf_d;
`endif

  // Current slice: operands shift right each RUN cycle, so the low CHUNK bits
  // are always the slice being added.
  always_comb begin
    slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
              + (CHUNK+1)'(carry_q);
    msb_cin   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice_sum[CHUNK-1];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          idx_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[32'(idx_q) * CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        carry_d = slice_sum[CHUNK];
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NSLICE - 1)) begin
          cout_d  = slice_sum[CHUNK];
`ifdef SERIAL_ADD_SUB_EN
          ovf_d   = msb_cin ^ slice_sum[CHUNK];
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_ADD_SUB_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADD_SUB_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench for serial_chunk_adder (WIDTH=32, CHUNK=8).
module tb_serial_chunk_adder;

  localparam int unsigned W      = 32;
  localparam int unsigned C      = 8;
  localparam int unsigned NSLICE = W / C;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   rand_rdy = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  serial_chunk_adder_if #(.WIDTH(W)) bus ();

  serial_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic msub);
    exp_t   e;
    longint sa, sb, r;
    logic [W:0] u;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      u      = {1'b0, ma} - {1'b0, mb} - (W+1)'(mc);
      e.sum  = u[W-1:0];
      e.cout = ({1'b0, ma} >= ({1'b0, mb} + (W+1)'(mc)));
      r      = sa - sb - longint'(mc);
    end else begin
      u      = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
      e.sum  = u[W-1:0];
      e.cout = u[W];
      r      = sa + sb + longint'(mc);
    end
    e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return e;
  endfunction

  // Monitor: every completed handshake is checked against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got sum %h with no pending operation", bus.sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", bus.sum, e.sum);
        check("cout", W'(bus.cout), W'(e.cout));
`ifdef SERIAL_ADD_SUB_EN
        check("ovf", W'(bus.ovf), W'(e.ovf));
`endif
      end
    end
  end

  // Offer one operation; called at posedge+1, returns at posedge+1 after accept.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc, input logic ts, input exp_t e);
    int  n = 0;
    bit  done = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = ta;
    bus.b = tb_v;
    bus.cin = tc;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = ts;
`endif
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      n++;
      if (!done && n > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: in_ready never rose, got 0, expected 1");
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (ts) begin end
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [W-1:0] cap_sum;
    logic         cap_cout;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    exp_t         e;
    int           n;

    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.a = 32'h1234_5678;
    bus.b = 32'h1111_1111;
    bus.cin = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif

    // Reset held 3 cycles with in_valid asserted.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_sum", bus.sum, '0);
    check("rst_cout", W'(bus.cout), W'(0));
`ifdef SERIAL_ADD_SUB_EN
    check("rst_ovf", W'(bus.ovf), W'(0));
`endif
    @(posedge clk); #1;

    // All-ones plus one: full carry ripple, plus latency check.
    e.sum = 32'h0; e.cout = 1'b1; e.ovf = 1'b0;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, e);
    for (int i = 0; i < int'(NSLICE); i++) begin
      @(negedge clk);
      check("latency_low", W'(bus.out_valid), W'(0));
      @(posedge clk);
    end
    @(negedge clk);
    check("latency_high", W'(bus.out_valid), W'(1));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Carry crossing slice boundaries.
    e.sum = 32'h0100_0101; e.cout = 1'b0; e.ovf = 1'b0;
    send(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, e);
    drain();
    bus.out_ready = 1'b0;

    // Backpressure: result held, new operands refused.
    e = model(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0);
    send(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0, e);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_done", W'(bus.out_valid), W'(1));
    cap_sum  = bus.sum;
    cap_cout = bus.cout;
    bus.in_valid = 1'b1;
    bus.a = 32'h0000_0003;
    bus.b = 32'h0000_0004;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_sum_stable", bus.sum, cap_sum);
      check("bp_cout_stable", W'(bus.cout), W'(cap_cout));
      check("bp_in_ready", W'(bus.in_ready), W'(0));
      check("bp_out_valid", W'(bus.out_valid), W'(1));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset during slice 2, then a fresh add must see no stale carry.
    e = model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_in_ready", W'(bus.in_ready), W'(1));
    check("midrst_out_valid", W'(bus.out_valid), W'(0));
    @(posedge clk); #1;
    e.sum = 32'd12; e.cout = 1'b0; e.ovf = 1'b0;
    send(32'd5, 32'd7, 1'b0, 1'b0, e);
    drain();

`ifdef SERIAL_ADD_SUB_EN
    // Subtract across the signed boundary.
    e.sum = 32'h7FFF_FFFF; e.cout = 1'b1; e.ovf = 1'b1;
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1, e);
    drain();
`endif

    // Randomized traffic with random backpressure and idle gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'hFFFF_FFFF;
        1: rb = ~ra;
        2: ra = 32'h7FFF_FFFF;
        default: ;
      endcase
      rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
    rand_rdy = 1'b0;
    drain();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
